display_arbiter: RTL and testbench
==================================

Name: display_arbiter

Overview:
Shares the single 4-digit seven-segment display between up to NUM_REQ requesters, such as a counter, a debug bus and a keypad echo. It uses round-robin arbitration with a guaranteed minimum display time per owner. The output disp_data feeds the 16-bit data_in of the seven-segment driver (nibble [15:12] = leftmost digit). A requester holds req high while it wants the display. gnt tells it that its data_flat slice is being shown.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
HOLD_CYCLES, 50000000, minimum clk cycles an owner keeps the display (1 s at 50 MHz); must be >= 1
CNT_W, 26, width of the hold counter; must satisfy 2^CNT_W > HOLD_CYCLES
IDLE_VALUE, 16'h0000, value driven on disp_data when nobody owns the display

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
req  input  NUM_REQ  per-requester display request, level-sensitive
data_flat  input  16*NUM_REQ  requester i data at [16*i+15:16*i]
gnt  output  NUM_REQ  one-hot grant; all-zero when no owner
owner  output  3  index of current or last owner
busy  output  1  high in OWN and GAP states
disp_data  output  16  value to the seven-segment driver, registered

Behaviour:
- All outputs are registered.
- Reset (rst=1 at a posedge): state=IDLE, gnt=0, owner=0, busy=0, disp_data=IDLE_VALUE, hold counter cnt=0, last_owner=NUM_REQ-1. Reset overrides every other event, including mid-hold.
- States: IDLE, OWN, GAP.
- Arbitration is round-robin. Search starts at (last_owner+1) mod NUM_REQ and wraps; the first requester with req=1 wins. After reset, req0 has the highest priority. A just-released requester has the lowest priority.
- IDLE, req==0: stay in IDLE. disp_data=IDLE_VALUE, gnt=0.
- IDLE, any req=1 in cycle t: at t+1 state=OWN, gnt=onehot(winner), owner=winner, last_owner=winner, disp_data=data of winner sampled at t, cnt=0, busy=1. Latency is 1 cycle.
- OWN, each cycle:
  - if req[owner]=1: disp_data <= data of owner (1-cycle live update).
  - if req[owner]=0: disp_data is frozen at its last value.
  - cnt increments and saturates at HOLD_CYCLES-1.
  - min_met = (cnt == HOLD_CYCLES-1).
- OWN release condition, evaluated when min_met: (req[owner]=0) OR (any other req=1). On release the next state is GAP.
- OWN with min_met, owner still requesting, no other requester: stay in OWN indefinitely, with live updates.
- The owner dropping req before min_met does not release. The display stays frozen until min_met, then releases.
- GAP, exactly 1 cycle: gnt=0, disp_data is held, busy=1.
  - Next cycle: arbitrate as in IDLE. If a winner exists, go to OWN at the following cycle edge. Otherwise go to IDLE with disp_data=IDLE_VALUE and busy=0.
  - gnt never switches directly between two requesters.
- HOLD_CYCLES=1: min_met is true on the first OWN cycle. The release check still applies.
- req changes during GAP are sampled at the arbitration edge only.
- Width rule: owner is zero-extended to 3 bits. Bits of req at index >= NUM_REQ do not exist.

Decomposition:
- Package disp_arb_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_OWN=2'd1, ST_GAP=2'd2
  - DATA_W=16
  - OWNER_W=3
- Sub-module rr_picker: combinational; inputs req and last_owner; outputs found and idx.
- Top level holds the FSM, the hold counter and the data mux/register.

Test Plan (HOLD_CYCLES=4, NUM_REQ=4):
1. Reset: rst=1 for 2 cycles with req=4'b1111 -> gnt=0, busy=0, disp_data=16'h0000, owner=0. First grant after rst falls is req0.
2. Single request: req1 rises at cycle t with data1=16'h1234 -> at t+1 gnt=4'b0010 and disp_data=16'h1234. Data1 changed to 16'hABCD -> disp_data=16'hABCD one cycle later.
3. Contention: req0 and req2 rise together -> gnt=0001 for 4 cycles, then 1 GAP cycle with gnt=0000, then gnt=0100.
4. Early drop: req1 is granted and then dropped after 2 OWN cycles -> gnt stays 0010 until the 4th OWN cycle, disp_data frozen. Then GAP, then IDLE with disp_data=16'h0000 and busy=0.
5. All four requesting continuously -> grant order 0,1,2,3,0, period 5 cycles (4 OWN + 1 GAP). gnt is always one-hot or zero.
6. Reset mid-hold: rst=1 during the 2nd OWN cycle of req3 -> next cycle gnt=0 and disp_data=16'h0000. After release, req0 and req3 pending -> req0 granted.

Source files
------------

// File: rtl/disp_arb_pkg.sv
// Shared definitions for the display arbiter.
// Contents:
//   DATA_W  - width of one requester's display word (four hex digits)
//   OWNER_W - width of the owner index output
//   state_t - arbiter FSM state encoding
package disp_arb_pkg;

  localparam int DATA_W  = 16;
  localparam int OWNER_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: finds the first active request starting one position
// after last_owner and wrapping around.
// Ports:
//   req        - request vector, one bit per requester
//   last_owner - index of the most recent owner (lowest priority)
//   found      - high when any request is active
//   idx        - index of the winning requester (valid when found)
module rr_picker
  import disp_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OWNER_W-1:0] last_owner,
  output logic               found,
  output logic [OWNER_W-1:0] idx
);

  logic [3:0]         start;
  logic [NUM_REQ-1:0] rot;
  logic [3:0]         pos;

  // Rotating a doubled copy of req puts the highest-priority requester at
  // bit 0, so a plain lowest-set-bit search gives round-robin order.
  assign start = {1'b0, last_owner} + 4'd1;
  assign rot   = NUM_REQ'({req, req} >> start);

  // Lowest set bit of the rotated vector, mapped back to a requester index.
  // start + j never exceeds 2*NUM_REQ-1, so one subtraction wraps it.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        pos   = start + 4'(j);
        if (pos >= 4'(NUM_REQ)) begin
          pos = pos - 4'(NUM_REQ);
        end
        idx = pos[OWNER_W-1:0];
      end
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// Shares the 4-digit seven-segment display between NUM_REQ requesters using
// round-robin arbitration with a guaranteed minimum hold time per owner and
// a one-cycle gap between owners.
// Ports:
//   clk       - system clock
//   rst       - synchronous, active-high reset
//   req       - per-requester level-sensitive display request
//   data_flat - requester i display word at [16*i+15:16*i]
//   gnt       - one-hot grant, all-zero when nobody owns the display
//   owner     - index of the current or last owner
//   busy      - high while owning or in the gap between owners
//   disp_data - registered word for the seven-segment driver
module display_arbiter
  import disp_arb_pkg::*;
#(
  parameter int                NUM_REQ     = 4,
  parameter int                HOLD_CYCLES = 50000000,
  parameter int                CNT_W       = 26,
  parameter logic [DATA_W-1:0] IDLE_VALUE  = 16'h0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [DATA_W*NUM_REQ-1:0] data_flat,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [OWNER_W-1:0]        owner,
  output logic                      busy,
  output logic [DATA_W-1:0]         disp_data
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [OWNER_W-1:0] last_owner;

  logic               pick_found;
  logic [OWNER_W-1:0] pick_idx;
  logic [DATA_W-1:0]  win_data;
  logic [DATA_W-1:0]  owner_data;
  logic               owner_req;
  logic [NUM_REQ-1:0] win_onehot;
  logic               others_req;
  logic               min_met;

  rr_picker #(
    .NUM_REQ(NUM_REQ)
  ) u_picker (
    .req       (req),
    .last_owner(last_owner),
    .found     (pick_found),
    .idx       (pick_idx)
  );

  // Select the winner's and the current owner's data and request bits with
  // compare-based muxes, so indices narrower than OWNER_W never appear.
  always_comb begin
    win_data   = '0;
    owner_data = '0;
    owner_req  = 1'b0;
    win_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == OWNER_W'(i)) begin
        win_data      = data_flat[DATA_W*i +: DATA_W];
        win_onehot[i] = 1'b1;
      end
      if (owner == OWNER_W'(i)) begin
        owner_data = data_flat[DATA_W*i +: DATA_W];
        owner_req  = req[i];
      end
    end
  end

  // While owning, gnt is exactly the owner's bit, so masking with it leaves
  // only competing requests.
  assign others_req = |(req & ~gnt);
  assign min_met    = (cnt == CNT_W'(HOLD_CYCLES - 1));

  // Arbiter FSM. IDLE and GAP share the arbitration step; GAP always lasts a
  // single cycle, so gnt never moves directly between two requesters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      gnt        <= '0;
      owner      <= '0;
      busy       <= 1'b0;
      disp_data  <= IDLE_VALUE;
      cnt        <= '0;
      last_owner <= OWNER_W'(NUM_REQ - 1);
    end else begin
      case (state)
        ST_IDLE, ST_GAP: begin
          if (pick_found) begin
            state      <= ST_OWN;
            gnt        <= win_onehot;
            owner      <= pick_idx;
            last_owner <= pick_idx;
            disp_data  <= win_data;
            cnt        <= '0;
            busy       <= 1'b1;
          end else begin
            state     <= ST_IDLE;
            gnt       <= '0;
            busy      <= 1'b0;
            disp_data <= IDLE_VALUE;
          end
        end
        ST_OWN: begin
          // Live update while the owner still requests; frozen otherwise.
          if (owner_req) begin
            disp_data <= owner_data;
          end
          if (!min_met) begin
            cnt <= cnt + CNT_W'(1);
          end
          if (min_met && (!owner_req || others_req)) begin
            state <= ST_GAP;
            gnt   <= '0;
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_arbiter.sv
// Directed testbench for display_arbiter with NUM_REQ=4 and HOLD_CYCLES=4.
// Inputs change 1 time unit after each rising edge and outputs are checked
// at that same point, i.e. they reflect the edge just taken.
module tb_display_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int HOLD_CYCLES = 4;
  localparam int CNT_W       = 3;

  logic                 clk;
  logic                 rst;
  logic [NUM_REQ-1:0]   req;
  logic [15:0]          dataArr [NUM_REQ];
  logic [16*NUM_REQ-1:0] dataFlat;
  logic [NUM_REQ-1:0]   gnt;
  logic [2:0]           owner;
  logic                 busy;
  logic [15:0]          dispData;

  int checks = 0;
  int errors = 0;

  assign dataFlat = {dataArr[3], dataArr[2], dataArr[1], dataArr[0]};

  display_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .HOLD_CYCLES(HOLD_CYCLES),
    .CNT_W      (CNT_W),
    .IDLE_VALUE (16'h0000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data_flat(dataFlat),
    .gnt      (gnt),
    .owner    (owner),
    .busy     (busy),
    .disp_data(dispData)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive a request pattern and take one clock edge.
  task automatic applyStimulus(input logic [NUM_REQ-1:0] r);
    req = r;
    tick();
  endtask

  // Reset for one edge with default requester data.
  task automatic doReset();
    rst        = 1'b1;
    req        = '0;
    dataArr[0] = 16'h1111;
    dataArr[1] = 16'h1234;
    dataArr[2] = 16'h2222;
    dataArr[3] = 16'h3333;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    req        = 4'b1111;
    dataArr[0] = 16'h1111;
    dataArr[1] = 16'h1234;
    dataArr[2] = 16'h2222;
    dataArr[3] = 16'h3333;

    // Reset held two cycles with all requests active.
    tick();
    tick();
    checkOutput("rst_gnt", 32'(gnt), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_disp", 32'(dispData), 32'h0000);
    checkOutput("rst_owner", 32'(owner), 32'h0);
    rst = 1'b0;
    applyStimulus(4'b1111);
    checkOutput("rst_first_gnt", 32'(gnt), 32'h1);
    checkOutput("rst_first_disp", 32'(dispData), 32'h1111);

    // Single requester, live data update, indefinite hold when alone.
    doReset();
    applyStimulus(4'b0010);
    checkOutput("single_gnt", 32'(gnt), 32'h2);
    checkOutput("single_disp", 32'(dispData), 32'h1234);
    checkOutput("single_busy", 32'(busy), 32'h1);
    checkOutput("single_owner", 32'(owner), 32'h1);
    dataArr[1] = 16'hABCD;
    applyStimulus(4'b0010);
    checkOutput("single_live", 32'(dispData), 32'hABCD);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(4'b0010);
      checkOutput("single_hold", 32'(gnt), 32'h2);
    end

    // Contention between req0 and req2.
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b0101);
      checkOutput("cont_gnt0", 32'(gnt), 32'h1);
    end
    applyStimulus(4'b0101);
    checkOutput("cont_gap_gnt", 32'(gnt), 32'h0);
    checkOutput("cont_gap_busy", 32'(busy), 32'h1);
    checkOutput("cont_gap_disp", 32'(dispData), 32'h1111);
    applyStimulus(4'b0101);
    checkOutput("cont_gnt2", 32'(gnt), 32'h4);
    checkOutput("cont_disp2", 32'(dispData), 32'h2222);
    checkOutput("cont_owner2", 32'(owner), 32'h2);

    // Owner drops before the minimum hold: frozen until released.
    doReset();
    applyStimulus(4'b0010);
    checkOutput("drop_gnt_c1", 32'(gnt), 32'h2);
    applyStimulus(4'b0010);
    checkOutput("drop_gnt_c2", 32'(gnt), 32'h2);
    dataArr[1] = 16'h5555;
    applyStimulus(4'b0000);
    checkOutput("drop_gnt_c3", 32'(gnt), 32'h2);
    checkOutput("drop_frozen", 32'(dispData), 32'h1234);
    applyStimulus(4'b0000);
    checkOutput("drop_gnt_c4", 32'(gnt), 32'h2);
    applyStimulus(4'b0000);
    checkOutput("drop_gap_gnt", 32'(gnt), 32'h0);
    checkOutput("drop_gap_busy", 32'(busy), 32'h1);
    checkOutput("drop_gap_disp", 32'(dispData), 32'h1234);
    applyStimulus(4'b0000);
    checkOutput("drop_idle_disp", 32'(dispData), 32'h0000);
    checkOutput("drop_idle_busy", 32'(busy), 32'h0);
    checkOutput("drop_idle_gnt", 32'(gnt), 32'h0);
    checkOutput("drop_idle_owner", 32'(owner), 32'h1);

    // Everyone requesting: order 0,1,2,3,0 with a gap between owners.
    doReset();
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 4; c++) begin
        applyStimulus(4'b1111);
        checkOutput("rr_gnt", 32'(gnt), 32'(4'b0001 << (k % 4)));
        checkOutput("rr_onehot", 32'($onehot0(gnt)), 32'h1);
      end
      checkOutput("rr_disp", 32'(dispData), 32'(dataArr[k % 4]));
      if (k < 4) begin
        applyStimulus(4'b1111);
        checkOutput("rr_gap", 32'(gnt), 32'h0);
      end
    end

    // Reset during the second owning cycle of req3.
    doReset();
    applyStimulus(4'b1000);
    checkOutput("mid_gnt3", 32'(gnt), 32'h8);
    applyStimulus(4'b1000);
    checkOutput("mid_gnt3_c2", 32'(gnt), 32'h8);
    rst = 1'b1;
    applyStimulus(4'b1001);
    checkOutput("mid_rst_gnt", 32'(gnt), 32'h0);
    checkOutput("mid_rst_disp", 32'(dispData), 32'h0000);
    checkOutput("mid_rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    applyStimulus(4'b1001);
    checkOutput("mid_after_gnt", 32'(gnt), 32'h1);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(4'b1001);
      checkOutput("mid_after_hold", 32'(gnt), 32'h1);
    end
    applyStimulus(4'b1001);
    checkOutput("mid_after_gap", 32'(gnt), 32'h0);
    applyStimulus(4'b1001);
    checkOutput("mid_after_gnt3", 32'(gnt), 32'h8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
